// File: rtl/encryption_top.sv
// Iterative AES-128 encryption core: one round per clock with on-the-fly key expansion.
// Result after 10 round edges; ciphertext, done and busy are all registered.
module encryption_top #(
   parameter bit CLEAR_ON_START = 1'b1
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         start,
   input  logic [127:0] plaintext,
   input  logic [127:0] key,
   output logic [127:0] ciphertext,
   output logic         done,
   output logic         busy
);

   localparam logic [2047:0] SBOX_TBL = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

   typedef enum logic [1:0] {IDLE, RUN, FINAL} state_t;

   function automatic logic [7:0] sb(input logic [7:0] b);
      return SBOX_TBL[2047 - 8*int'(b) -: 8];
   endfunction

   function automatic logic [7:0] xt(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] rcon(input logic [3:0] rnd);
      case (rnd)
         4'd1:    return 8'h01;
         4'd2:    return 8'h02;
         4'd3:    return 8'h04;
         4'd4:    return 8'h08;
         4'd5:    return 8'h10;
         4'd6:    return 8'h20;
         4'd7:    return 8'h40;
         4'd8:    return 8'h80;
         4'd9:    return 8'h1b;
         4'd10:   return 8'h36;
         default: return 8'h00;
      endcase
   endfunction

   // Byte i lives at [127-8i]; row = i%4, col = i/4. Row r rotates left by r columns.
   function automatic logic [127:0] sub_shift(input logic [127:0] s);
      logic [127:0] o;
      o = '0;
      for (int i = 0; i < 16; i++) begin
         int r, c, src;
         r   = i % 4;
         c   = i / 4;
         src = r + 4 * ((c + r) % 4);
         o[127 - 8*i -: 8] = sb(s[127 - 8*src -: 8]);
      end
      return o;
   endfunction

   function automatic logic [127:0] mix(input logic [127:0] s);
      logic [127:0] o;
      logic [7:0]   a0, a1, a2, a3;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         a0 = s[127 - 32*c -: 8];
         a1 = s[119 - 32*c -: 8];
         a2 = s[111 - 32*c -: 8];
         a3 = s[103 - 32*c -: 8];
         o[127 - 32*c -: 32] = {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                                a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                                a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                                xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
      end
      return o;
   endfunction

   function automatic logic [127:0] expand(input logic [127:0] k, input logic [7:0] rc);
      logic [31:0] w0, w1, w2, w3, w4, w5, w6, w7;
      {w0, w1, w2, w3} = k;
      w4 = w0 ^ {sb(w3[23:16]), sb(w3[15:8]), sb(w3[7:0]), sb(w3[31:24])} ^ {rc, 24'h0};
      w5 = w4 ^ w1;
      w6 = w5 ^ w2;
      w7 = w6 ^ w3;
      return {w4, w5, w6, w7};
   endfunction

   state_t       r_fsm;
   logic [3:0]   r_round;
   logic [127:0] r_state, r_rk, r_ct;
   logic         r_done, r_busy;

   logic [127:0] w_sr, w_rk_next;

   assign w_sr      = sub_shift(r_state);
   assign w_rk_next = expand(r_rk, rcon(r_round));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_fsm   <= IDLE;
         r_round <= 4'd0;
         r_state <= '0;
         r_rk    <= '0;
         r_ct    <= '0;
         r_done  <= 1'b0;
         r_busy  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_fsm)
            IDLE: if (start) begin
               r_state <= plaintext ^ key;
               r_rk    <= key;
               r_round <= 4'd1;
               r_busy  <= 1'b1;
               r_fsm   <= RUN;
               if (CLEAR_ON_START) r_ct <= '0;
            end
            RUN: begin
               r_state <= mix(w_sr) ^ w_rk_next;
               r_rk    <= w_rk_next;
               r_round <= r_round + 4'd1;
               if (r_round == 4'd9) r_fsm <= FINAL;
            end
            FINAL: begin
               // Last round skips MixColumns.
               r_ct    <= w_sr ^ w_rk_next;
               r_done  <= 1'b1;
               r_busy  <= 1'b0;
               r_round <= 4'd0;
               r_fsm   <= IDLE;
            end
            default: r_fsm <= IDLE;
         endcase
      end
   end

   assign ciphertext = r_ct;
   assign done       = r_done;
   assign busy       = r_busy;

endmodule

// File: tb/tb_encryption_top.sv
// Directed bench for encryption_top: FIPS-197 vectors, ignored starts,
// back-to-back and held starts, and asynchronous reset mid-block.
module tb_encryption_top;

   logic         clk = 1'b0;
   logic         reset_n;
   logic         start;
   logic [127:0] plaintext, key;
   logic [127:0] ciphertext;
   logic         done, busy;

   int errors = 0;
   int checks = 0;

   localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] P1  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] K2  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] P2  = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] C2  = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] CZ  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

   encryption_top #(.CLEAR_ON_START(1'b1)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .start      (start),
      .plaintext  (plaintext),
      .key        (key),
      .ciphertext (ciphertext),
      .done       (done),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one block for a single edge, then scramble the inputs.
   task automatic start_blk(input logic [127:0] k, input logic [127:0] p);
      start = 1'b1; key = k; plaintext = p;
      tick();
      start = 1'b0;
      key = {4{$urandom()}}; plaintext = {4{$urandom()}};
   endtask

   task automatic wait_done(output int n);
      n = 0;
      do begin
         tick();
         n++;
      end while (!done && n < 30);
   endtask

   int n, n2, ndone;
   logic [127:0] cap;

   initial begin
      reset_n = 1'b0; start = 1'b0; key = '0; plaintext = '0;
      repeat (2) tick();
      chk("rst_ct",   ciphertext, '0);
      chk("rst_done", done, 0);
      chk("rst_busy", busy, 0);
      reset_n = 1'b1;
      tick();

      // FIPS-197 C.1 with latency
      start_blk(K1, P1);
      chk("c1_busy", busy, 1);
      chk("c1_clear", ciphertext, '0);
      wait_done(n);
      chk("c1_lat", n, 10);
      chk("c1_ct", ciphertext, C1);
      chk("c1_busy_done", busy, 0);
      tick();
      chk("c1_done_low", done, 0);
      tick();
      chk("c1_hold", ciphertext, C1);

      // FIPS-197 App B
      start_blk(K2, P2);
      chk("b_clear", ciphertext, '0);
      wait_done(n);
      chk("b_lat", n, 10);
      chk("b_ct", ciphertext, C2);
      tick();

      // All-zero, start re-pulsed mid-block
      start_blk('0, '0);
      ndone = 0; cap = '0;
      for (int j = 1; j <= 25; j++) begin
         start = (j == 3 || j == 7);
         tick();
         if (done) begin
            ndone++;
            cap = ciphertext;
            chk("z_lat", j, 10);
         end
      end
      start = 1'b0;
      chk("z_ndone", ndone, 1);
      chk("z_ct", cap, CZ);

      // Back-to-back: start in the done cycle
      start_blk(K1, P1);
      wait_done(n);
      chk("bb_ct1", ciphertext, C1);
      start = 1'b1; key = K2; plaintext = P2;
      tick();
      start = 1'b0;
      chk("bb_busy", busy, 1);
      wait_done(n2);
      chk("bb_gap", n2 + 1, 11);
      chk("bb_ct2", ciphertext, C2);
      tick();

      // Reset mid-operation
      start_blk(K2, P2);
      repeat (5) tick();
      reset_n = 1'b0;
      #1;
      chk("ar_ct", ciphertext, '0);
      chk("ar_busy", busy, 0);
      chk("ar_done", done, 0);
      tick();
      reset_n = 1'b1;
      ndone = 0;
      for (int j = 0; j < 15; j++) begin
         tick();
         if (done) ndone++;
      end
      chk("ar_nodone", ndone, 0);
      start_blk(K1, P1);
      wait_done(n);
      chk("ar_lat", n, 10);
      chk("ar_ct1", ciphertext, C1);
      tick();

      // Start held high re-triggers every 11 clocks
      start = 1'b1; key = '0; plaintext = '0;
      wait_done(n);
      chk("hold_ct1", ciphertext, CZ);
      wait_done(n2);
      chk("hold_gap", n2, 11);
      chk("hold_ct2", ciphertext, CZ);
      start = 1'b0;
      repeat (12) tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
